picorv_mem_arbiter: RTL and testbench

Round-robin arbiter that shares one PicoRV32-native memory port (the port feeding the PicoRV32-to-FreeAHB adapter) between NREQ native-interface requesters, e.g. a second core or a boot loader/DMA. It registers the winning request, drives it downstream, and returns the response only to the granted requester. A watchdog answers any stalled downstream transfer with an error word, so no requester can hang the AHB master.

---
 rtl/picorv_arb_pkg.sv | 12 +
 rtl/picorv_mem_arbiter_rr_pick.sv | 32 +++
 rtl/picorv_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_picorv_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv_arb_pkg.sv
// Shared definitions for the PicoRV32 native-port round-robin arbiter.
package picorv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/picorv_mem_arbiter_rr_pick.sv
// Rotating priority encoder: first set valid bit at or after the pointer, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [GW-1:0]   i_ptr,
  output logic [GW-1:0]   o_idx,
  output logic            o_any
);

  int          w_pos;
  logic [GW-1:0] w_cand;

  // Walk from farthest to nearest so the closest hit to the pointer wins.
  always_comb begin
    o_idx  = i_ptr;
    o_any  = 1'b0;
    w_pos  = 0;
    w_cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      w_cand = GW'(w_pos);
      if (i_valid[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/picorv_mem_arbiter.sv
// Round-robin arbiter sharing one PicoRV32 native memory port among NREQ requesters,
// with a watchdog that forces an error response on a stalled downstream transfer.
//
// state | meaning
// IDLE  | waiting for any req_valid; latches the winner's request
// BUSY  | mem_valid held with latched fields until mem_ready or watchdog expiry
// RESP  | one-cycle req_ready to the owner; advances the round-robin pointer
module picorv_mem_arbiter
  import picorv_arb_pkg::*;
#(
  parameter int          NREQ     = 2,
  parameter int          TIMEOUT  = 1023,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_instr,
  input  logic [32*NREQ-1:0]       req_addr,
  input  logic [32*NREQ-1:0]       req_wdata,
  input  logic [4*NREQ-1:0]        req_wstrb,
  output logic [NREQ-1:0]          req_ready,
  output logic [31:0]              req_rdata,
  output logic                     mem_valid,
  output logic                     mem_instr,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wstrb,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_rdata,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     timeout_err
);

  localparam int GW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] r_grant_id;
  logic [WW-1:0] r_wd;
  logic          r_mem_valid;
  logic          r_mem_instr;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_mem_wstrb;
  logic [NREQ-1:0] r_req_ready;
  logic [31:0]   r_req_rdata;
  logic          r_timeout_err;

  logic [GW-1:0] w_pick;
  logic          w_any;
  logic          w_grant;
  logic          w_done_ok;
  logic          w_done_to;
  logic          w_resp;

  rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_rr_pick (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick),
    .o_any   (w_any)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done_ok   = 1'b0;
    w_done_to   = 1'b0;
    w_resp      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A completion on the expiry cycle wins over the forced error.
        if (mem_ready) begin
          w_done_ok   = 1'b1;
          w_state_nxt = RESP;
        end else if (r_wd == WW'(TIMEOUT)) begin
          w_done_to   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_resp      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_wd          <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_instr   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_wstrb   <= '0;
      r_req_ready   <= '0;
      r_req_rdata   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_req_ready   <= '0;
      r_timeout_err <= 1'b0;
      if (w_grant) begin
        r_grant_id  <= w_pick;
        r_mem_addr  <= req_addr[32*int'(w_pick) +: 32];
        r_mem_wdata <= req_wdata[32*int'(w_pick) +: 32];
        r_mem_wstrb <= req_wstrb[4*int'(w_pick) +: 4];
        r_mem_instr <= req_instr[w_pick];
        r_wd        <= '0;
        r_mem_valid <= 1'b1;
      end
      if (r_state == BUSY && !w_done_ok && !w_done_to) begin
        r_wd <= r_wd + WW'(1);
      end
      if (w_done_ok || w_done_to) begin
        r_req_rdata <= w_done_ok ? mem_rdata : ERR_DATA;
        r_mem_valid <= 1'b0;
        r_req_ready <= NREQ'(1) << r_grant_id;
      end
      if (w_done_to) begin
        r_timeout_err <= 1'b1;
      end
      if (w_resp) begin
        r_rr_ptr <= (r_grant_id == GW'(NREQ - 1)) ? '0 : r_grant_id + GW'(1);
      end
    end
  end

  assign req_ready   = r_req_ready;
  assign req_rdata   = r_req_rdata;
  assign mem_valid   = r_mem_valid;
  assign mem_instr   = r_mem_instr;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wstrb   = r_mem_wstrb;
  assign grant_id    = r_grant_id;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_picorv_mem_arbiter.sv
// Directed bench for picorv_mem_arbiter with a transaction-level reference model checked every cycle.
module tb_picorv_mem_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 15;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  req_valid, req_instr;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  req_ready;
  logic [31:0] req_rdata;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [0:0]  grant_id;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  picorv_mem_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .req_valid   (req_valid),
    .req_instr   (req_instr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .req_ready   (req_ready),
    .req_rdata   (req_rdata),
    .mem_valid   (mem_valid),
    .mem_instr   (mem_instr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Reference model: one outstanding transaction, owner chosen by rotating priority.
  int          m_phase = 0;  // 0 waiting, 1 downstream outstanding, 2 responding
  int          m_ptr = 0, m_owner = 0, m_busy = 0;
  logic        m_mv = 0, m_instr = 0, m_to = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic [3:0]  m_wstrb = 0;
  logic [1:0]  m_ready = 0;

  function automatic int pick(input logic [1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (((v >> ((p + k) % NREQ)) & 2'b01) != 2'b00) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge HCLK) begin
    int w;
    if (HRESET) begin
      m_phase = 0; m_ptr = 0; m_owner = 0; m_busy = 0;
      m_mv = 0; m_instr = 0; m_to = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_wstrb = 0; m_ready = 0;
    end else if (m_phase == 0) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_addr  = 32'(req_addr >> (32 * w));
        m_wdata = 32'(req_wdata >> (32 * w));
        m_wstrb = 4'(req_wstrb >> (4 * w));
        m_instr = ((req_instr >> w) & 2'b01) != 2'b00;
        m_mv    = 1;
        m_busy  = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_busy = m_busy + 1;
      if (mem_ready || m_busy == TIMEOUT + 1) begin
        m_rdata = mem_ready ? mem_rdata : 32'hDEAD_BEEF;
        m_to    = !mem_ready;
        m_ready = 2'(1 << m_owner);
        m_mv    = 0;
        m_phase = 2;
      end
    end else begin
      m_ready = 0;
      m_to    = 0;
      m_ptr   = (m_owner + 1) % NREQ;
      m_phase = 0;
    end
  end

  always @(negedge HCLK) begin
    if (cmp_en) begin
      chk("mdl_mem_valid", mem_valid, m_mv);
      if (m_mv) begin
        chk("mdl_mem_addr", mem_addr, m_addr);
        chk("mdl_mem_wdata", mem_wdata, m_wdata);
        chk("mdl_mem_instr_wstrb", {mem_instr, mem_wstrb}, {m_instr, m_wstrb});
      end
      chk("mdl_grant_id", grant_id, m_owner);
      chk("mdl_req_ready", req_ready, m_ready);
      chk("mdl_timeout_err", timeout_err, m_to);
      if (m_ready != 0 && m_wstrb == 0) chk("mdl_req_rdata", req_rdata, m_rdata);
    end
  end

  task automatic wait_mv(input string nm, output int n);
    n = 0;
    while (mem_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk(nm, mem_valid, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, npulse;
    int pc[4];
    logic [1:0] pid[4];

    HRESET = 1; req_valid = 0; req_instr = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
    tick();
    cmp_en = 1;
    tick();
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_req_rdata", req_rdata, 32'h0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_mem_fields", {mem_addr, mem_wdata, mem_wstrb, mem_instr}, 69'h0);
    HRESET = 0;

    // Single read, two wait states
    req_addr[31:0] = 32'h4000_0000; req_instr = 2'b01; req_valid = 2'b01;
    wait_mv("t1_grant", n);
    chk("t1_latency", n, 1);
    chk("t1_mem_addr", mem_addr, 32'h4000_0000);
    tick(); tick();
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    tick();
    chk("t1_req_ready", req_ready, 2'b01);
    chk("t1_req_rdata", req_rdata, 32'h1234_5678);
    mem_ready = 0; req_valid = 0;
    tick();
    chk("t1_ready_one_cycle", req_ready, 2'b00);
    tick(); tick();

    // Contention from reset, zero-wait downstream
    HRESET = 1; req_valid = 2'b11; req_instr = 2'b00;
    req_addr = {32'h2000_0004, 32'h1000_0000};
    mem_ready = 1; mem_rdata = 32'hCAFE_0000;
    tick(); tick();
    HRESET = 0;
    npulse = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (req_ready != 2'b00 && npulse < 4) begin
        pc[npulse] = i;
        pid[npulse] = req_ready;
        npulse++;
      end
    end
    chk("t2_pulses", npulse, 4);
    chk("t2_first_cycle", pc[0], 2);
    for (int j = 0; j < 4; j++) begin
      chk("t2_grant_order", pid[j], (j % 2 == 0) ? 2'b01 : 2'b10);
      if (j > 0) chk("t2_spacing", pc[j] - pc[j-1], 3);
    end
    req_valid = 0; mem_ready = 0; HRESET = 1;
    tick(); tick();
    HRESET = 0;
    tick();

    // Write pass-through from requester 1
    req_addr[63:32] = 32'h5000_0010; req_wdata[63:32] = 32'hAABB_CCDD;
    req_wstrb[7:4] = 4'b0011; req_valid = 2'b10;
    wait_mv("t3_grant", n);
    for (int c = 0; c < 4; c++) begin
      chk("t3_fields_held", {mem_valid, mem_addr, mem_wdata, mem_wstrb},
          {1'b1, 32'h5000_0010, 32'hAABB_CCDD, 4'b0011});
      chk("t3_grant_id", grant_id, 1'b1);
      if (c < 3) tick();
    end
    mem_ready = 1;
    tick();
    chk("t3_req_ready", req_ready, 2'b10);
    mem_ready = 0; req_valid = 0; req_wstrb = 0;
    tick(); tick();

    // Watchdog timeout, then the other requester is served
    req_addr = {32'h2000_0020, 32'h1000_0010}; req_valid = 2'b11;
    wait_mv("t4_grant", n);
    chk("t4_grant_id", grant_id, 1'b0);
    n = 0;
    while (req_ready == 2'b00 && n < 40) begin
      if (mem_valid) n++;
      tick();
    end
    chk("t4_busy_cycles", n, 16);
    chk("t4_timeout_err", timeout_err, 1'b1);
    chk("t4_req_ready", req_ready, 2'b01);
    chk("t4_err_data", req_rdata, 32'hDEAD_BEEF);
    req_valid = 2'b10;
    tick();
    chk("t4_err_one_cycle", timeout_err, 1'b0);
    wait_mv("t4_next_grant", n);
    chk("t4_next_id", grant_id, 1'b1);
    chk("t4_next_addr", mem_addr, 32'h2000_0020);
    mem_ready = 1;
    tick();
    mem_ready = 0; req_valid = 0;
    tick(); tick();

    // mem_ready exactly on the expiry cycle
    req_addr[31:0] = 32'h1000_0040; req_valid = 2'b01;
    wait_mv("t5_grant", n);
    for (int c = 0; c < 15; c++) tick();
    chk("t5_still_busy", mem_valid, 1'b1);
    chk("t5_no_early_resp", req_ready, 2'b00);
    mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    tick();
    chk("t5_req_ready", req_ready, 2'b01);
    chk("t5_no_error", timeout_err, 1'b0);
    chk("t5_real_data", req_rdata, 32'h5555_AAAA);
    mem_ready = 0; req_valid = 0;
    tick(); tick();

    // Reset while a transfer is outstanding
    req_addr = {32'h2000_0080, 32'h1000_0080}; req_valid = 2'b11;
    wait_mv("t6_grant", n);
    chk("t6_rr_grant", grant_id, 1'b1);
    tick(); tick();
    HRESET = 1;
    tick();
    chk("t6_rst_mem_valid", mem_valid, 1'b0);
    chk("t6_rst_req_ready", req_ready, 2'b00);
    chk("t6_rst_grant_id", grant_id, 1'b0);
    HRESET = 0;
    wait_mv("t6_regrant", n);
    chk("t6_regrant_id", grant_id, 1'b0);
    chk("t6_regrant_addr", mem_addr, 32'h1000_0080);
    mem_ready = 1;
    tick();
    mem_ready = 0; req_valid = 0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
